// File: rtl/femto_bus_ic_if.sv
// CPU-side memory bus plus the per-slave select/strobe/busy/data channels.
// slave: the interconnect's view; master: the CPU core and peripherals' view.
interface femto_bus_ic_if #(
  parameter int unsigned NSLAVES = 8
);
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_rstrb;
  logic [31:0]           mem_rdata;
  logic                  mem_rbusy;
  logic                  mem_wbusy;
  logic [NSLAVES-1:0]    s_cs;
  logic [NSLAVES-1:0]    s_rd;
  logic [NSLAVES-1:0]    s_wr;
  logic [NSLAVES*32-1:0] s_rdata;
  logic [NSLAVES-1:0]    s_rbusy;
  logic [NSLAVES-1:0]    s_wbusy;

  // Write data goes straight from the core to the slaves, so the interconnect never sees it.
  modport slave (
    input  mem_addr, mem_wmask, mem_rstrb, s_rdata, s_rbusy, s_wbusy,
    output mem_rdata, mem_rbusy, mem_wbusy, s_cs, s_rd, s_wr
  );

  modport master (
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb, s_rdata, s_rbusy, s_wbusy,
    input  mem_rdata, mem_rbusy, mem_wbusy, s_cs, s_rd, s_wr
  );
endinterface

// File: rtl/femto_bus_ic.sv
// Memory-mapped interconnect between the FemtoRV32 core and NSLAVES peripherals:
// programmable decode, busy aggregation, busy timeout and sticky error status.
module femto_bus_ic #(
  parameter int unsigned                    NSLAVES       = 8,
  parameter int unsigned                    DEC_LO        = 16,
  parameter logic [NSLAVES*(32-DEC_LO)-1:0] SLAVE_BASE    = {16'h0044, 16'h0043, 16'h0042, 16'h0041,
                                                             16'h0040, 16'h0001, 16'h0000, 16'h0000},
  parameter logic [NSLAVES-1:0]             SLAVE_EN      = {NSLAVES{1'b1}},
  parameter int unsigned                    DEFAULT_SLAVE = 0,
  parameter int unsigned                    TIMEOUT       = 255
) (
  input  logic                clk,
  input  logic                reset,
  femto_bus_ic_if.slave       bus,
  input  logic                err_clr,
  output logic                err_valid,
  output logic [1:0]          err_code,
  output logic [31:0]         err_addr
);
  localparam int unsigned DW = 32 - DEC_LO;
  localparam int unsigned IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            force_q, force_d, force_now;
  logic [31:0]     addr_q, addr_d;
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [NSLAVES-1:0] cs, rd_stb, wr_stb;
  logic            rbusy, wbusy, sel_rbusy, sel_wbusy, wr_req;
  logic            err_set;
  logic [1:0]      err_code_d;
  logic [31:0]     err_addr_d;

  // Address decode: the lowest enabled slot whose base matches wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    cs      = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (SLAVE_EN[i] && (bus.mem_addr[31:DEC_LO] == SLAVE_BASE[i*DW +: DW])) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    if (hit) cs[hit_idx] = 1'b1;
  end

  assign sel_rbusy = bus.s_rbusy[rd_idx_q];
  assign sel_wbusy = bus.s_wbusy[wr_idx_q];
  assign wr_req    = |bus.mem_wmask;

  // Next-state, strobes, busy and error events.
  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    cnt_d      = cnt_q;
    force_d    = force_q;
    force_now  = 1'b0;
    addr_d     = addr_q;
    rd_stb     = '0;
    wr_stb     = '0;
    rbusy      = 1'b0;
    wbusy      = 1'b0;
    err_set    = 1'b0;
    err_code_d = 2'b00;
    err_addr_d = bus.mem_addr;
    case (state_q)
      IDLE: begin
        if (bus.mem_rstrb) begin
          if (hit) begin
            rd_stb   = cs;
            rd_idx_d = hit_idx;
            cnt_d    = '0;
            force_d  = 1'b0;
            addr_d   = bus.mem_addr;
            state_d  = RD_WAIT;
          end else begin
            force_d    = 1'b1;
            force_now  = 1'b1;
            err_set    = 1'b1;
            err_code_d = ERR_UNMAPPED;
          end
        end else if (wr_req) begin
          if (hit) begin
            wr_stb   = cs;
            wr_idx_d = hit_idx;
            cnt_d    = '0;
            addr_d   = bus.mem_addr;
            state_d  = WR_WAIT;
          end else begin
            err_set    = 1'b1;
            err_code_d = ERR_UNMAPPED;
          end
        end
      end
      RD_WAIT: begin
        if (!sel_rbusy) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          force_d    = 1'b1;
          force_now  = 1'b1;
          err_set    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = addr_q;
          state_d    = IDLE;
        end else begin
          rbusy = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_WAIT: begin
        if (!sel_wbusy) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          force_d    = 1'b1;
          force_now  = 1'b1;
          err_set    = 1'b1;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = addr_q;
          state_d    = IDLE;
        end else begin
          wbusy = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_idx_q <= IW'(DEFAULT_SLAVE);
      wr_idx_q <= IW'(DEFAULT_SLAVE);
      cnt_q    <= '0;
      force_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
      force_q  <= force_d;
      addr_q   <= addr_d;
    end
  end

  // First error wins; a clear in the same cycle as a new error lets the new one in.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid <= 1'b0;
      err_code  <= 2'b00;
      err_addr  <= '0;
    end else if (err_set && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_code  <= err_code_d;
      err_addr  <= err_addr_d;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_code  <= 2'b00;
      err_addr  <= '0;
    end
  end

  // Strobes are suppressed while reset is held so an aborted access is never re-issued.
  assign bus.s_cs      = cs;
  assign bus.s_rd      = reset ? '0 : rd_stb;
  assign bus.s_wr      = reset ? '0 : wr_stb;
  assign bus.mem_rbusy = rbusy;
  assign bus.mem_wbusy = wbusy;
  assign bus.mem_rdata = (force_q || force_now) ? 32'h0 : bus.s_rdata[32*rd_idx_q +: 32];

endmodule
